// File: rtl/nes_pkg.sv
// Shared NES CPU-bus constants and the autopoll state encoding used by joypad_port.
package nes_pkg;

  localparam logic [15:0] JOY1_ADDR   = 16'h4016;
  localparam logic [15:0] JOY2_ADDR   = 16'h4017;
  localparam logic [2:0]  OPEN_BUS_HI = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SAMPLE,
    SHIFT,
    COMMIT
  } poll_state_t;

  // Controller reads only drive bit 0; the upper bits mimic the open-bus value.
  function automatic logic [7:0] bus_byte(input logic pad_bit);
    return {OPEN_BUS_HI, 4'b0000, pad_bit};
  endfunction

endpackage

// File: rtl/joypad_port_if.sv
// CPU-side bus signals seen by the controller port; the CPU model is master.
interface joypad_port_if;
  logic        m2;
  logic        rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;

  modport master (
    output m2, rw, cpu_addr, cpu_data_in,
    input  cpu_data_out, cpu_data_oe
  );

  modport slave (
    input  m2, rw, cpu_addr, cpu_data_in,
    output cpu_data_out, cpu_data_oe
  );
endinterface

// File: rtl/joy_sync.sv
// Two-flop synchroniser for one active-low pad data line; resets to 1 (no button).
module joy_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/joypad_port.sv
// NES controller port at $4016/$4017: strobe latch, per-pad clock pulses, serial read-back.
// Build option JOYPAD_AUTOPOLL_EN: the block polls the pads itself and serves an emulated shift register.
//
// state  | meaning (autopoll build only)
// IDLE   | wait POLL_PERIOD cycles between polls
// LATCH  | joy_strobe high for POLL_HALF cycles
// SAMPLE | capture one bit from each pad
// SHIFT  | joy_clk high POLL_HALF, low POLL_HALF
// COMMIT | copy both captures into the shadows
module joypad_port
  import nes_pkg::*;
#(
  parameter int CLK_PULSE_CYCLES = 2,
  parameter int POLL_PERIOD      = 29830,
  parameter int POLL_HALF        = 6
) (
  input  logic          clk,
  input  logic          reset,
  joypad_port_if.slave  bus,
  output logic          joy_strobe,
  output logic [1:0]    joy_clk,
  input  logic [1:0]    joy_data_n
);

  logic       m2_q;
  logic [1:0] hit;
  logic       access_end;
  logic       rd_end;
  logic       wr_end;
  logic [1:0] sync_data;
  logic       pad_sel;
  logic       read_bit;
  logic       unused_data_hi;

  if (CLK_PULSE_CYCLES < 1 || POLL_HALF < 1 || POLL_PERIOD < 2) begin : g_bad_params
    $error("joypad_port: pulse/poll parameters out of range");
  end

  assign hit        = {bus.cpu_addr == JOY2_ADDR, bus.cpu_addr == JOY1_ADDR};
  assign access_end = m2_q & ~bus.m2;
  assign rd_end     = access_end & bus.rw;
  assign wr_end     = access_end & ~bus.rw;
  assign pad_sel    = hit[1];

  assign bus.cpu_data_oe  = bus.m2 & bus.rw & (|hit);
  assign bus.cpu_data_out = bus_byte(read_bit);
  assign unused_data_hi   = &{1'b0, bus.cpu_data_in[7:1]};

  always_ff @(posedge clk) begin
    if (reset) m2_q <= 1'b0;
    else       m2_q <= bus.m2;
  end

  for (genvar n = 0; n < 2; n++) begin : g_sync
    joy_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (joy_data_n[n]),
      .q     (sync_data[n])
    );
  end

`ifdef JOYPAD_AUTOPOLL_EN

  localparam int TMAX = (POLL_PERIOD > 2 * POLL_HALF) ? POLL_PERIOD : 2 * POLL_HALF;
  localparam int TW   = $clog2(TMAX + 1);

  poll_state_t   state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic          cap_en;
  logic          commit;
  logic          strobe_pin;
  logic          clk_pin;
  logic          cpu_strobe;
  logic [7:0]    capture [2];
  logic [7:0]    shadow  [2];
  logic [7:0]    shift   [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= TW'(POLL_PERIOD - 1);
      bit_idx <= 3'd0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = (timer == '0) ? '0 : timer - TW'(1);
    bit_nxt    = bit_idx;
    cap_en     = 1'b0;
    commit     = 1'b0;
    strobe_pin = 1'b0;
    clk_pin    = 1'b0;
    case (state)
      IDLE: begin
        if (timer == '0) begin
          state_nxt = LATCH;
          timer_nxt = TW'(POLL_HALF - 1);
          bit_nxt   = 3'd0;
        end
      end
      LATCH: begin
        strobe_pin = 1'b1;
        if (timer == '0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        cap_en = 1'b1;
        if (bit_idx == 3'd7) begin
          state_nxt = COMMIT;
        end else begin
          state_nxt = SHIFT;
          timer_nxt = TW'(2 * POLL_HALF - 1);
        end
      end
      SHIFT: begin
        // Upper half of the countdown is the high phase of the pad clock.
        clk_pin = (timer >= TW'(POLL_HALF));
        if (timer == '0) begin
          state_nxt = SAMPLE;
          bit_nxt   = bit_idx + 3'd1;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
        timer_nxt = TW'(POLL_PERIOD - 1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_strobe <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        capture[n] <= 8'h00;
        shadow[n]  <= 8'h00;
        shift[n]   <= 8'h00;
      end
    end else begin
      if (wr_end & hit[0]) cpu_strobe <= bus.cpu_data_in[0];
      for (int n = 0; n < 2; n++) begin
        if (cap_en) capture[n][bit_idx] <= ~sync_data[n];
        if (commit) shadow[n] <= capture[n];
        if (cpu_strobe)              shift[n] <= shadow[n];
        else if (rd_end & hit[n])    shift[n] <= {1'b1, shift[n][7:1]};
      end
    end
  end

  assign joy_strobe = strobe_pin;
  assign joy_clk    = {2{clk_pin}};
  assign read_bit   = shift[pad_sel][0];

`else

  localparam int CW = $clog2(CLK_PULSE_CYCLES + 1);

  logic [CW-1:0] pulse_cnt [2];

  // A read during an active pulse reloads, so back-to-back reads give one unbroken pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      joy_strobe   <= 1'b0;
      pulse_cnt[0] <= '0;
      pulse_cnt[1] <= '0;
    end else begin
      if (wr_end & hit[0]) joy_strobe <= bus.cpu_data_in[0];
      for (int n = 0; n < 2; n++) begin
        if (rd_end & hit[n])          pulse_cnt[n] <= CW'(CLK_PULSE_CYCLES);
        else if (pulse_cnt[n] != '0)  pulse_cnt[n] <= pulse_cnt[n] - CW'(1);
      end
    end
  end

  assign joy_clk  = {pulse_cnt[1] != '0, pulse_cnt[0] != '0};
  assign read_bit = ~sync_data[pad_sel];

`endif

endmodule

// File: tb/tb_joypad_port.sv
// Self-checking bench for joypad_port: vector table through a scoreboard queue plus corner sequences.
module tb_joypad_port;
  import nes_pkg::*;

  localparam int PULSE       = 2;
  localparam int POLL_PERIOD = 29830;
  localparam int POLL_HALF   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       joy_strobe;
  logic [1:0] joy_clk;
  logic [1:0] joy_data_n;

  joypad_port_if bus ();

  joypad_port #(
    .CLK_PULSE_CYCLES (PULSE),
    .POLL_PERIOD      (POLL_PERIOD),
    .POLL_HALF        (POLL_HALF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .joy_strobe (joy_strobe),
    .joy_clk    (joy_clk),
    .joy_data_n (joy_data_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [1:0]  pad;
    logic        exp_oe;
    logic [7:0]  exp_data;
    logic        exp_strobe;
    logic [1:0]  exp_clk;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU access; returns the observed bus and pin values around the m2 falling edge.
  task automatic bus_cycle(input logic rw_i, input logic [15:0] a, input logic [7:0] wd,
                           output logic [7:0] rdata, output logic oe_mid, output logic oe_after,
                           output logic st_before, output logic st_at_e, output logic [5:0] clk_seq);
    bus.cpu_addr    = a;
    bus.rw          = rw_i;
    bus.cpu_data_in = wd;
    tick();
    bus.m2 = 1'b1;
    tick();
    tick();
    rdata     = bus.cpu_data_out;
    oe_mid    = bus.cpu_data_oe;
    st_before = joy_strobe;
    bus.m2    = 1'b0;
    #1;
    oe_after  = bus.cpu_data_oe;
    tick();
    st_at_e      = joy_strobe;
    clk_seq[1:0] = joy_clk;
    tick();
    clk_seq[3:2] = joy_clk;
    tick();
    clk_seq[5:4] = joy_clk;
    bus.cpu_addr = 16'h0000;
    bus.rw       = 1'b1;
  endtask

`ifdef JOYPAD_AUTOPOLL_EN
  localparam logic [7:0] PAD1_BTNS = 8'b1010_0011;
  localparam logic [7:0] PAD2_BTNS = 8'b0101_1100;
  logic [7:0] p0 = 8'h00;
  logic [7:0] p1 = 8'h00;
  logic [1:0] joy_clk_d = 2'b00;

  // 4021-style pad: parallel load while strobe is high, shift on rising clock, pressed = low.
  always @(posedge clk) begin
    joy_clk_d <= joy_clk;
    if (joy_strobe) begin
      p0 <= PAD1_BTNS;
      p1 <= PAD2_BTNS;
    end else begin
      if (joy_clk[0] && !joy_clk_d[0]) p0 <= {1'b0, p0[7:1]};
      if (joy_clk[1] && !joy_clk_d[1]) p1 <= {1'b0, p1[7:1]};
    end
  end

  always_comb joy_data_n = ~{p1[0], p0[0]};
`endif

  initial begin
    logic [7:0] rdata;
    logic       oe_mid, oe_after, st_before, st_at_e;
    logic [5:0] clk_seq;
`ifndef JOYPAD_AUTOPOLL_EN
    vec_t       vecs [12];
    vec_t       exp_q [$];
    vec_t       e;
    logic       prev_strobe;
    int         hi_run, hi_total;
    logic       seen_low, clk0_seen;
`else
    logic       exp_bits [$];
    logic       eb;
    int         strobe_hi, clk_rises;
    logic       clk_prev;
`endif

    bus.m2          = 1'b0;
    bus.rw          = 1'b1;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_data_in = 8'h00;
`ifndef JOYPAD_AUTOPOLL_EN
    joy_data_n = 2'b11;
`endif
    repeat (3) tick();

    check("reset_strobe", 32'(joy_strobe), 32'h0);
    check("reset_clk", 32'(joy_clk), 32'h0);
    check("reset_oe", 32'(bus.cpu_data_oe), 32'h0);
    check("reset_data", 32'(bus.cpu_data_out), 32'h40);
    reset = 1'b0;
    tick();

`ifndef JOYPAD_AUTOPOLL_EN
    //            rw    addr      wd     pad    oe    data   strobe clk
    vecs[0]  = '{1'b0, 16'h4016, 8'h01, 2'b11, 1'b0, 8'h00, 1'b1, 2'b00};
    vecs[1]  = '{1'b0, 16'h4016, 8'h00, 2'b11, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[2]  = '{1'b1, 16'h4016, 8'h00, 2'b10, 1'b1, 8'h41, 1'b0, 2'b01};
    vecs[3]  = '{1'b1, 16'h4017, 8'h00, 2'b10, 1'b1, 8'h40, 1'b0, 2'b10};
    vecs[4]  = '{1'b1, 16'h4017, 8'h00, 2'b01, 1'b1, 8'h41, 1'b0, 2'b10};
    vecs[5]  = '{1'b0, 16'h4017, 8'h01, 2'b11, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 16'h4016, 8'h01, 2'b11, 1'b0, 8'h00, 1'b1, 2'b00};
    vecs[7]  = '{1'b1, 16'h4016, 8'h00, 2'b00, 1'b1, 8'h41, 1'b1, 2'b01};
    vecs[8]  = '{1'b0, 16'h4016, 8'hFE, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[9]  = '{1'b1, 16'h4015, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 16'h4016, 8'h03, 2'b11, 1'b0, 8'h00, 1'b1, 2'b00};
    vecs[11] = '{1'b1, 16'h4016, 8'h00, 2'b11, 1'b1, 8'h40, 1'b1, 2'b01};

    prev_strobe = 1'b0;
    for (int i = 0; i < 12; i++) begin
      joy_data_n = vecs[i].pad;
      repeat (3) tick();
      exp_q.push_back(vecs[i]);
      bus_cycle(vecs[i].rw, vecs[i].addr, vecs[i].wd, rdata, oe_mid, oe_after, st_before, st_at_e, clk_seq);
      e = exp_q.pop_front();
      check($sformatf("v%0d_oe_mid", i), 32'(oe_mid), 32'(e.exp_oe));
      check($sformatf("v%0d_oe_after", i), 32'(oe_after), 32'h0);
      if (e.exp_oe) check($sformatf("v%0d_data", i), 32'(rdata), 32'(e.exp_data));
      check($sformatf("v%0d_strobe_before", i), 32'(st_before), 32'(prev_strobe));
      check($sformatf("v%0d_strobe_at_end", i), 32'(st_at_e), 32'(e.exp_strobe));
      // PULSE = 2: high on the two cycles after access end, low on the third.
      check($sformatf("v%0d_clk_seq", i), 32'(clk_seq), 32'({2'b00, e.exp_clk, e.exp_clk}));
      prev_strobe = e.exp_strobe;
    end

    // Earliest second access end is two edges after the first, so the pulse spans 2 + PULSE cycles.
    bus.cpu_addr = 16'h4017;
    bus.rw       = 1'b1;
    tick();
    bus.m2 = 1'b1;
    tick();
    tick();
    bus.m2    = 1'b0;
    hi_run    = 0;
    hi_total  = 0;
    seen_low  = 1'b0;
    clk0_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) bus.m2 = 1'b1;
      if (c == 1) bus.m2 = 1'b0;
      if (joy_clk[0]) clk0_seen = 1'b1;
      if (joy_clk[1]) begin
        hi_total++;
        if (!seen_low) hi_run++;
      end else begin
        seen_low = 1'b1;
      end
    end
    bus.cpu_addr = 16'h0000;
    check("b2b_run", 32'(hi_run), 32'(2 + PULSE));
    check("b2b_total", 32'(hi_total), 32'(2 + PULSE));
    check("b2b_pad1_clk", 32'(clk0_seen), 32'h0);

    // Reset one cycle into a pulse.
    bus.cpu_addr = 16'h4016;
    bus.rw       = 1'b1;
    tick();
    bus.m2 = 1'b1;
    tick();
    tick();
    bus.m2 = 1'b0;
    tick();
    check("rst_pulse_start", 32'(joy_clk), 32'h1);
    reset = 1'b1;
    tick();
    check("rst_pulse_drop", 32'(joy_clk), 32'h0);
    reset = 1'b0;
    tick();
    check("rst_pulse_no_resume", 32'(joy_clk), 32'h0);
    check("rst_strobe_cleared", 32'(joy_strobe), 32'h0);

    // Reset mid-write: the falling m2 during reset must not update the strobe.
    bus.rw          = 1'b0;
    bus.cpu_data_in = 8'h01;
    tick();
    bus.m2 = 1'b1;
    tick();
    reset  = 1'b1;
    bus.m2 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rst_mid_access_strobe", 32'(joy_strobe), 32'h0);
    check("rst_mid_access_clk", 32'(joy_clk), 32'h0);
    bus.rw       = 1'b1;
    bus.cpu_addr = 16'h0000;
`else
    strobe_hi = 0;
    clk_rises = 0;
    clk_prev  = 1'b0;
    for (int c = 0; c < POLL_PERIOD + 400; c++) begin
      tick();
      if (joy_strobe) strobe_hi++;
      if (joy_clk[0] && !clk_prev) clk_rises++;
      clk_prev = joy_clk[0];
    end
    check("poll_latch_cycles", 32'(strobe_hi), 32'(POLL_HALF));
    check("poll_clk_rises", 32'(clk_rises), 32'h7);

    bus_cycle(1'b0, 16'h4016, 8'h01, rdata, oe_mid, oe_after, st_before, st_at_e, clk_seq);
    check("ap_write_oe", 32'(oe_mid), 32'h0);
    bus_cycle(1'b0, 16'h4016, 8'h00, rdata, oe_mid, oe_after, st_before, st_at_e, clk_seq);

    for (int i = 0; i < 10; i++) exp_bits.push_back(i < 8 ? PAD1_BTNS[i] : 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus_cycle(1'b1, 16'h4016, 8'h00, rdata, oe_mid, oe_after, st_before, st_at_e, clk_seq);
      eb = exp_bits.pop_front();
      check($sformatf("ap_pad1_read%0d", i), 32'(rdata), 32'(bus_byte(eb)));
      if (i == 0) check("ap_read_oe", 32'(oe_mid), 32'h1);
    end
    for (int i = 0; i < 3; i++) exp_bits.push_back(PAD2_BTNS[i]);
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b1, 16'h4017, 8'h00, rdata, oe_mid, oe_after, st_before, st_at_e, clk_seq);
      eb = exp_bits.pop_front();
      check($sformatf("ap_pad2_read%0d", i), 32'(rdata), 32'(bus_byte(eb)));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
